pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Pipeline control unit for the 3-stage F/D/E(W) core.
- Drives the 2-bit `update` codes consumed by the fetch/decode, decode/execute and execute/writeback pipeline registers, plus the PC write enable.
- Resolves four conditions: multi-cycle execute waits, load-use hazards, branch/jump redirects and the stop instruction.
- Owns the only sequential control state in the pipeline: the wait counter and the run/halt FSM.

Parameters:
- WAIT_W, 5, width of the wait-time field and counter.

Ports:
- clk  in  1  clock
- rstn  in  1  reset; one clock, synchronous, active-low
- d_rs  in  6  decode source s; bit5 selects float file
- d_rt  in  6  decode source t; bit5 selects float file
- d_uses_s  in  1  decode instruction reads s
- d_uses_t  in  1  decode instruction reads t
- d_wait_time  in  WAIT_W  extra execute cycles for the decode instruction
- de_rw  in  2  E-stage write class; 00 none, 01 int, 1x float
- de_rd  in  5  E-stage destination
- de_is_load  in  1  E-stage instruction is a load; result not forwardable from E
- de_stop  in  1  E-stage instruction is stop
- e_redirect  in  1  E-stage branch taken, jump or jr resolved; PC loads target
- restart  in  1  leave HALT
- fd_update  out  2  to F/D register
- de_update  out  2  to D/E register
- ew_update  out  2  to E/W register
- pc_we  out  1  PC register write enable
- halted  out  1  FSM in HALT
- stalled  out  1  hold or bubble issued this cycle

Behaviour:
- Update codes: 00 HOLD, 01 ADVANCE, 10 FLUSH (bubble). Code 11 is never driven.
- FSM states: RUN, WAIT, HALT. State is registered; all outputs are combinational from state, counter and inputs.
- Reset (rstn=0, sampled at clk):
  - next state RUN, wait_cnt=0.
  - While rstn=0, outputs are forced to: all updates 00, pc_we=0, halted=0, stalled=0.
- Priority per cycle, highest first: reset > HALT > WAIT > stop > redirect > load-use > normal.
- HALT:
  - Outputs: updates 00/00/00, pc_we=0, halted=1.
  - restart=1 → RUN next cycle. Outputs are still frozen in the cycle restart is sampled.
- WAIT (wait_cnt≠0):
  - Outputs: fd=00, de=00, ew=10, pc_we=0, stalled=1.
  - wait_cnt decrements each cycle.
  - At wait_cnt==1, next state is RUN. The E instruction completes in the following cycle under the RUN rules.
  - Stop, redirect and load-use are ignored while in WAIT.
- Stop (RUN, de_stop=1):
  - Outputs: fd=10, de=10, ew=01, pc_we=0.
  - Next state HALT. Stop outranks a simultaneous redirect.
- Redirect (RUN, e_redirect=1):
  - Outputs: fd=10, de=10, ew=01, pc_we=1.
  - Exactly one cycle; no repeat.
- Load-use (RUN), asserted when de_is_load && de_rw≠00 and either:
  - d_uses_s && de_rw[1]==d_rs[5] && de_rd==d_rs[4:0], or
  - the same test on t.
  - Outputs: fd=00, de=10, ew=01, pc_we=0, stalled=1.
  - Stalls exactly 1 cycle because the bubble clears the hazard.
- Normal: fd=01, de=01, ew=01, pc_we=1.
- Counter load:
  - de_update==01 → wait_cnt ← d_wait_time, and next state is WAIT if d_wait_time≠0.
  - de_update==10 → wait_cnt ← 0.
  - Otherwise decrement in WAIT, hold elsewhere.
  - d_wait_time=31 gives 31 stall cycles. The counter never wraps because the decrement is gated by ≠0.
- Reset mid-WAIT or mid-HALT: state returns to RUN and wait_cnt to 0 on the next edge.

Decomposition:
- Shared package pipe_pkg holds:
  - typedef upd_t (2 bits) with constants UPD_HOLD, UPD_ADV, UPD_FLUSH.
  - enum ctrl_state_t {RUN, WAIT, HALT}.
  - The rw encoding constants RW_NONE, RW_INT, RW_FLT.
- One natural combinational sub-module, load_use_detect. It holds the match logic and mirrors the forwarding-unit comparison.

Test Plan:
- Reset held 2 cycles, then released with no hazards → updates 00 during reset, then 01/01/01 with pc_we=1 every cycle.
- Inputs d_wait_time=3 with de_update=01 → next 3 cycles fd=00, de=00, ew=10, stalled=1; 4th cycle 01/01/01.
- E holds a load (de_rw=01, de_rd=7, de_is_load=1); decode has d_rs=6'd7, d_uses_s=1 → one cycle of fd=00, de=10, ew=01; with d_rs=6'h27 (float 7) → no stall.
- e_redirect=1 together with a load-use match → fd=10, de=10, ew=01, pc_we=1; load-use suppressed.
- de_stop=1 → 10/10/01, then HALT with all 00 and halted=1; restart pulse → one more frozen cycle, then normal.
- rstn=0 pulsed during WAIT with wait_cnt=5 → after release, immediately 01/01/01 and wait_cnt=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the F/D/E(W) pipeline control unit.
//   upd_t         : 2-bit pipeline-register update code (HOLD/ADV/FLUSH)
//   ctrl_state_t  : run/wait/halt controller state
//   RW_*          : E-stage write-class encoding (bit1 selects the float file)
package pipe_pkg;

  localparam int unsigned UPD_W  = 2;
  localparam int unsigned RW_W   = 2;
  localparam int unsigned REG_W  = 6;
  localparam int unsigned IDX_W  = 5;

  typedef logic [UPD_W-1:0] upd_t;

  localparam upd_t UPD_HOLD  = 2'b00;
  localparam upd_t UPD_ADV   = 2'b01;
  localparam upd_t UPD_FLUSH = 2'b10;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    HALT = 2'd2
  } ctrl_state_t;

  localparam logic [RW_W-1:0] RW_NONE = 2'b00;
  localparam logic [RW_W-1:0] RW_INT  = 2'b01;
  localparam logic [RW_W-1:0] RW_FLT  = 2'b10;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle between the pipeline datapath and the control unit.
//   master : datapath side; drives decode/execute status, receives update codes
//   slave  : control unit; samples status, drives fd/de/ew updates, pc_we,
//            halted and stalled
interface pipe_ctrl_if #(
  parameter int unsigned WAIT_W = 5
);
  import pipe_pkg::*;

  logic [REG_W-1:0]  d_rs;
  logic [REG_W-1:0]  d_rt;
  logic              d_uses_s;
  logic              d_uses_t;
  logic [WAIT_W-1:0] d_wait_time;
  logic [RW_W-1:0]   de_rw;
  logic [IDX_W-1:0]  de_rd;
  logic              de_is_load;
  logic              de_stop;
  logic              e_redirect;
  logic              restart;

  upd_t              fd_update;
  upd_t              de_update;
  upd_t              ew_update;
  logic              pc_we;
  logic              halted;
  logic              stalled;

  modport master (
    output d_rs, d_rt, d_uses_s, d_uses_t, d_wait_time,
           de_rw, de_rd, de_is_load, de_stop, e_redirect, restart,
    input  fd_update, de_update, ew_update, pc_we, halted, stalled
  );

  modport slave (
    input  d_rs, d_rt, d_uses_s, d_uses_t, d_wait_time,
           de_rw, de_rd, de_is_load, de_stop, e_redirect, restart,
    output fd_update, de_update, ew_update, pc_we, halted, stalled
  );

endinterface

// File: rtl/pipe_ctrl_load_use_detect.sv
// Load-use hazard detect: the decode instruction reads a register that the
// E-stage load will write, so the value cannot be forwarded yet.
//   i_rs/i_rt        : decode sources, bit5 selects the float file
//   i_uses_s/i_uses_t: decode actually reads that source
//   i_rw/i_rd        : E-stage write class and destination
//   i_is_load        : E-stage instruction is a load
//   o_hazard_c       : combinational hazard flag
module load_use_detect
  import pipe_pkg::*;
(
  input  logic [REG_W-1:0] i_rs,
  input  logic [REG_W-1:0] i_rt,
  input  logic             i_uses_s,
  input  logic             i_uses_t,
  input  logic [RW_W-1:0]  i_rw,
  input  logic [IDX_W-1:0] i_rd,
  input  logic             i_is_load,
  output logic             o_hazard_c
);

  logic w_load_writes;
  logic w_s_match;
  logic w_t_match;

  // Same comparison as the forwarding unit: file select plus register index.
  assign w_load_writes = i_is_load && (i_rw != RW_NONE);
  assign w_s_match     = i_uses_s && (i_rw[1] == i_rs[REG_W-1]) && (i_rd == i_rs[IDX_W-1:0]);
  assign w_t_match     = i_uses_t && (i_rw[1] == i_rt[REG_W-1]) && (i_rd == i_rt[IDX_W-1:0]);
  assign o_hazard_c    = w_load_writes && (w_s_match || w_t_match);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control unit for the 3-stage F/D/E(W) core. Produces the update
// codes for the F/D, D/E and E/W registers and the PC write enable, resolving
// multi-cycle execute waits, load-use hazards, redirects and stop.
//   clk, rstn : clock, synchronous active-low reset
//   bus       : pipe_ctrl_if slave (status in, update codes/pc_we/halted/stalled out)
// Outputs are combinational from state, wait counter and inputs.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned WAIT_W = 5
) (
  input  logic        clk,
  input  logic        rstn,
  pipe_ctrl_if.slave  bus
);

  ctrl_state_t       r_state;
  ctrl_state_t       w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_cnt_nxt;
  logic              w_load_use;

  upd_t              w_fd;
  upd_t              w_de;
  upd_t              w_ew;
  logic              w_pc_we;
  logic              w_halted;
  logic              w_stalled;

  load_use_detect u_lud (
    .i_rs       (bus.d_rs),
    .i_rt       (bus.d_rt),
    .i_uses_s   (bus.d_uses_s),
    .i_uses_t   (bus.d_uses_t),
    .i_rw       (bus.de_rw),
    .i_rd       (bus.de_rd),
    .i_is_load  (bus.de_is_load),
    .o_hazard_c (w_load_use)
  );

  // State and wait-counter register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  // Next state, counter update and update-code decode.
  always_comb begin
    w_fd           = UPD_HOLD;
    w_de           = UPD_HOLD;
    w_ew           = UPD_HOLD;
    w_pc_we        = 1'b0;
    w_halted       = 1'b0;
    w_stalled      = 1'b0;
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;

    if (!rstn) begin
      w_state_nxt    = RUN;
      w_wait_cnt_nxt = '0;
    end else begin
      case (r_state)
        HALT: begin
          w_halted = 1'b1;
          if (bus.restart) w_state_nxt = RUN;
        end

        WAIT: begin
          // E keeps executing; E/W gets bubbles until the last wait cycle.
          w_ew      = UPD_FLUSH;
          w_stalled = 1'b1;
          if (r_wait_cnt != '0) w_wait_cnt_nxt = r_wait_cnt - WAIT_W'(1);
          if (r_wait_cnt <= WAIT_W'(1)) w_state_nxt = RUN;
        end

        default: begin
          if (bus.de_stop) begin
            w_fd        = UPD_FLUSH;
            w_de        = UPD_FLUSH;
            w_ew        = UPD_ADV;
            w_state_nxt = HALT;
          end else if (bus.e_redirect) begin
            w_fd    = UPD_FLUSH;
            w_de    = UPD_FLUSH;
            w_ew    = UPD_ADV;
            w_pc_we = 1'b1;
          end else if (w_load_use) begin
            // Bubble into E; the load moves on so the hazard clears next cycle.
            w_fd      = UPD_HOLD;
            w_de      = UPD_FLUSH;
            w_ew      = UPD_ADV;
            w_stalled = 1'b1;
          end else begin
            w_fd    = UPD_ADV;
            w_de    = UPD_ADV;
            w_ew    = UPD_ADV;
            w_pc_we = 1'b1;
          end
        end
      endcase

      // The counter follows what enters E: a new instruction loads its wait
      // time, a bubble clears it.
      if (w_de == UPD_ADV) begin
        w_wait_cnt_nxt = bus.d_wait_time;
        if (bus.d_wait_time != '0) w_state_nxt = WAIT;
      end else if (w_de == UPD_FLUSH) begin
        w_wait_cnt_nxt = '0;
      end
    end
  end

  assign bus.fd_update = w_fd;
  assign bus.de_update = w_de;
  assign bus.ew_update = w_ew;
  assign bus.pc_we     = w_pc_we;
  assign bus.halted    = w_halted;
  assign bus.stalled   = w_stalled;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a stimulus process drives one input vector
// per cycle and pushes the reference model's expected outputs; a monitor pops
// and compares on the falling edge.
module tb_pipe_ctrl;
  import pipe_pkg::*;

  localparam int unsigned WAIT_W = 5;

  logic clk;
  logic rstn;

  pipe_ctrl_if #(.WAIT_W(WAIT_W)) bus ();

  pipe_ctrl #(.WAIT_W(WAIT_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rstn;
    logic [5:0] rs;
    logic [5:0] rt;
    logic       us;
    logic       ut;
    logic [4:0] wt;
    logic [1:0] rw;
    logic [4:0] rd;
    logic       ld;
    logic       stop;
    logic       redir;
    logic       restart;
  } stim_t;

  typedef struct {
    logic [1:0] fd;
    logic [1:0] de;
    logic [1:0] ew;
    logic       pc_we;
    logic       halted;
    logic       stalled;
    logic       chk_stalled;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc_no   = 0;

  // Reference model state: halted flag and number of stall cycles still owed.
  bit   m_halted     = 1'b0;
  int   m_stall_left = 0;

  // Register-file identity: file 0 = int, 1 = float; -1 means no write.
  function automatic bit reads_loaded_reg(input logic [5:0] src, input logic uses, input stim_t s);
    int wfile;
    int rfile;
    if (!uses || !s.ld) return 1'b0;
    if (s.rw == 2'd0) wfile = -1;
    else if (s.rw == 2'd1) wfile = 0;
    else wfile = 1;
    rfile = (int'(src) >= 32) ? 1 : 0;
    return (wfile == rfile) && (int'(s.rd) == (int'(src) % 32));
  endfunction

  function automatic exp_t model(input stim_t s);
    exp_t e;
    e.fd = 2'd0; e.de = 2'd0; e.ew = 2'd0;
    e.pc_we = 1'b0; e.halted = 1'b0; e.stalled = 1'b0;
    e.chk_stalled = 1'b1; e.cyc = cyc_no;
    if (!s.rstn) begin
      m_halted = 1'b0;
      m_stall_left = 0;
    end else if (m_halted) begin
      e.halted = 1'b1;
      e.chk_stalled = 1'b0;
      if (s.restart) m_halted = 1'b0;
    end else if (m_stall_left > 0) begin
      e.ew = 2'd2; e.stalled = 1'b1;
      m_stall_left = m_stall_left - 1;
    end else if (s.stop) begin
      e.fd = 2'd2; e.de = 2'd2; e.ew = 2'd1;
      m_halted = 1'b1;
    end else if (s.redir) begin
      e.fd = 2'd2; e.de = 2'd2; e.ew = 2'd1; e.pc_we = 1'b1;
    end else if (reads_loaded_reg(s.rs, s.us, s) || reads_loaded_reg(s.rt, s.ut, s)) begin
      e.fd = 2'd0; e.de = 2'd2; e.ew = 2'd1; e.stalled = 1'b1;
    end else begin
      e.fd = 2'd1; e.de = 2'd1; e.ew = 2'd1; e.pc_we = 1'b1;
      m_stall_left = int'(s.wt);
    end
    return e;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.rstn = 1'b1; s.rs = 6'd0; s.rt = 6'd0; s.us = 1'b0; s.ut = 1'b0;
    s.wt = 5'd0; s.rw = 2'd0; s.rd = 5'd0; s.ld = 1'b0;
    s.stop = 1'b0; s.redir = 1'b0; s.restart = 1'b0;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    @(posedge clk);
    #1;
    cyc_no++;
    rstn            = s.rstn;
    bus.d_rs        = s.rs;
    bus.d_rt        = s.rt;
    bus.d_uses_s    = s.us;
    bus.d_uses_t    = s.ut;
    bus.d_wait_time = s.wt;
    bus.de_rw       = s.rw;
    bus.de_rd       = s.rd;
    bus.de_is_load  = s.ld;
    bus.de_stop     = s.stop;
    bus.e_redirect  = s.redir;
    bus.restart     = s.restart;
    exp_q.push_back(model(s));
  endtask

  task automatic check(input string name, input int act, input int expv, input int cyc);
    n_checks++;
    if (act != expv) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, expv);
    end
  endtask

  // Monitor: outputs are presented every cycle, so one entry per falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("fd_update", int'(bus.fd_update), int'(e.fd), e.cyc);
      check("de_update", int'(bus.de_update), int'(e.de), e.cyc);
      check("ew_update", int'(bus.ew_update), int'(e.ew), e.cyc);
      check("pc_we",     int'(bus.pc_we),     int'(e.pc_we), e.cyc);
      check("halted",    int'(bus.halted),    int'(e.halted), e.cyc);
      if (e.chk_stalled) check("stalled", int'(bus.stalled), int'(e.stalled), e.cyc);
    end
  end

  initial begin
    stim_t s;
    rstn = 1'b0;
    bus.d_rs = '0; bus.d_rt = '0; bus.d_uses_s = 1'b0; bus.d_uses_t = 1'b0;
    bus.d_wait_time = '0; bus.de_rw = '0; bus.de_rd = '0; bus.de_is_load = 1'b0;
    bus.de_stop = 1'b0; bus.e_redirect = 1'b0; bus.restart = 1'b0;

    // Reset for two cycles, then free-running.
    s = idle(); s.rstn = 1'b0;
    apply(s); apply(s);
    repeat (3) apply(idle());

    // Three-cycle execute wait.
    s = idle(); s.wt = 5'd3;
    apply(s);
    repeat (4) apply(idle());

    // Int load to r7 with decode reading r7, then float f7 (no hazard).
    s = idle(); s.ld = 1'b1; s.rw = 2'd1; s.rd = 5'd7; s.rs = 6'd7; s.us = 1'b1;
    apply(s);
    apply(idle());
    s.rs = 6'h27;
    apply(s);
    s.rs = 6'd0; s.rt = 6'd7; s.us = 1'b0; s.ut = 1'b1;
    apply(s);
    apply(idle());

    // Redirect outranks load-use.
    s = idle(); s.ld = 1'b1; s.rw = 2'd1; s.rd = 5'd7; s.rs = 6'd7; s.us = 1'b1; s.redir = 1'b1;
    apply(s);
    apply(idle());

    // Stop (with a redirect alongside), halt, restart.
    s = idle(); s.stop = 1'b1; s.redir = 1'b1;
    apply(s);
    repeat (2) apply(idle());
    s = idle(); s.restart = 1'b1;
    apply(s);
    repeat (2) apply(idle());

    // Reset mid-wait.
    s = idle(); s.wt = 5'd5;
    apply(s);
    repeat (2) apply(idle());
    s = idle(); s.rstn = 1'b0;
    apply(s);
    repeat (3) apply(idle());

    // Maximum wait time.
    s = idle(); s.wt = 5'd31;
    apply(s);
    repeat (33) apply(idle());

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      int r;
      s.rstn    = ($urandom_range(0, 99) != 0);
      s.rs      = {1'($urandom_range(0, 1)), 5'($urandom_range(0, 3))};
      s.rt      = {1'($urandom_range(0, 1)), 5'($urandom_range(0, 3))};
      s.us      = 1'($urandom_range(0, 1));
      s.ut      = 1'($urandom_range(0, 1));
      s.rw      = 2'($urandom_range(0, 3));
      s.rd      = 5'($urandom_range(0, 3));
      s.ld      = 1'($urandom_range(0, 1));
      s.stop    = ($urandom_range(0, 99) < 3);
      s.redir   = ($urandom_range(0, 99) < 15);
      s.restart = ($urandom_range(0, 99) < 30);
      r = int'($urandom_range(0, 99));
      if (r < 80)      s.wt = 5'd0;
      else if (r < 97) s.wt = 5'($urandom_range(1, 6));
      else             s.wt = 5'd31;
      apply(s);
    end

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
